mips_mem_arbiter: RTL and testbench

Shares one Avalon-style memory bus between the CPU instruction-fetch port and the data port, so the harvard core can run against a single unified RAM.
- Fixed or round-robin arbitration.
- Grant is held until the bus completes (waitrequest low).
- Bus address and write data are registered at grant.
- Watchdog aborts transfers that hang.

---
 rtl/mips_mem_arbiter.sv | 102 ++++++++++
 tb/tb_mips_mem_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: shares one Avalon-style bus between instruction fetch and data ports.
// Define MIPS_ARB_RR_EN for round-robin arbitration; otherwise data has fixed priority.
module mips_mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] i_address,
   input  logic              i_read,
   output logic [DATA_W-1:0] i_readdata,
   output logic              i_waitrequest,
   input  logic [ADDR_W-1:0] d_address,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [3:0]        d_byteenable,
   input  logic [DATA_W-1:0] d_writedata,
   output logic [DATA_W-1:0] d_readdata,
   output logic              d_waitrequest,
   output logic [ADDR_W-1:0] m_address,
   output logic              m_read,
   output logic              m_write,
   output logic [3:0]        m_byteenable,
   output logic [DATA_W-1:0] m_writedata,
   input  logic [DATA_W-1:0] m_readdata,
   input  logic              m_waitrequest,
   output logic              err_timeout,
   output logic              err_protocol
);
   typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;
   localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
   state_t state, state_nx;
   logic [CW-1:0] cnt;
   logic d_req, pick_d, pick_i, granted, abort, fin, done_i, done_d;
   logic [DATA_W-1:0] fin_data;
   assign d_req = d_read | d_write;
`ifdef MIPS_ARB_RR_EN
   logic rr_i;
   assign pick_d = d_req && !(i_read && rr_i);
`else
   assign pick_d = d_req;
`endif
   assign pick_i = i_read && !pick_d;
   assign granted = state != IDLE;
   assign abort = granted && TIMEOUT > 0 && int'(cnt) == TIMEOUT;
   // A reset edge swallows any completion so neither requester sees a stray handshake
   assign fin = granted && (!m_waitrequest || abort) && !reset;
   assign done_i = fin && state == GRANT_I;
   assign done_d = fin && state == GRANT_D;
   assign fin_data = abort ? DATA_W'(32'hDEADBEEF) : m_readdata;
   assign i_waitrequest = !done_i;
   assign d_waitrequest = !done_d;
   assign i_readdata = done_i ? fin_data : '0;
   assign d_readdata = done_d ? fin_data : '0;
   always_comb begin
      state_nx = state;
      if (state == IDLE)
         state_nx = pick_d ? GRANT_D : pick_i ? GRANT_I : IDLE;
      else if (fin)
         state_nx = IDLE;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         m_address    <= '0;
         m_read       <= 1'b0;
         m_write      <= 1'b0;
         m_byteenable <= '0;
         m_writedata  <= '0;
         cnt          <= '0;
         err_timeout  <= 1'b0;
         err_protocol <= 1'b0;
`ifdef MIPS_ARB_RR_EN
         rr_i         <= 1'b0;
`endif
      end else begin
         state <= state_nx;
         if (state == IDLE) begin
            cnt <= '0;
            if (pick_d || pick_i) begin
               m_address    <= pick_d ? d_address : i_address;
               m_read       <= pick_d ? d_read && !d_write : 1'b1;
               m_write      <= pick_d && d_write;
               m_byteenable <= pick_d ? d_byteenable : 4'hF;
               m_writedata  <= pick_d ? d_writedata : '0;
               err_protocol <= err_protocol | (pick_d && d_read && d_write);
            end
         end else if (fin) begin
            m_read      <= 1'b0;
            m_write     <= 1'b0;
            cnt         <= '0;
            err_timeout <= err_timeout | abort;
`ifdef MIPS_ARB_RR_EN
            rr_i        <= !rr_i;
`endif
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end
endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb_mips_mem_arbiter: directed vectors plus a transaction-level reference model checked every cycle.
module tb_mips_mem_arbiter;
   localparam int TO = 8;
`ifdef MIPS_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif
   logic        clk = 1'b0, reset = 1'b1;
   logic [31:0] i_address = '0, d_address = '0, d_writedata = '0, m_readdata = '0;
   logic        i_read = 1'b0, d_read = 1'b0, d_write = 1'b0, m_waitrequest = 1'b0;
   logic [3:0]  d_byteenable = '0;
   logic [31:0] i_readdata, d_readdata, m_address, m_writedata;
   logic        i_waitrequest, d_waitrequest, m_read, m_write, err_timeout, err_protocol;
   logic [3:0]  m_byteenable;
   always #5 clk = ~clk;
   mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .i_address(i_address), .i_read(i_read), .i_readdata(i_readdata), .i_waitrequest(i_waitrequest),
      .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_byteenable(d_byteenable),
      .d_writedata(d_writedata), .d_readdata(d_readdata), .d_waitrequest(d_waitrequest),
      .m_address(m_address), .m_read(m_read), .m_write(m_write), .m_byteenable(m_byteenable),
      .m_writedata(m_writedata), .m_readdata(m_readdata), .m_waitrequest(m_waitrequest),
      .err_timeout(err_timeout), .err_protocol(err_protocol)
   );
   int checks = 0, passed = 0;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask
   // Reference model: who owns the bus (0 none, 1 fetch, 2 data) and what it should be driving
   int          owner = 0, stalls = 0;
   logic        e_rd = 0, e_wr = 0, e_to = 0, e_pr = 0, ptr_i = 0;
   logic [31:0] e_addr = 0, e_wd = 0;
   logic [3:0]  e_be = 0;
   wire ab = owner != 0 && stalls == TO;
   wire take_d = (d_read || d_write) && !(RR && i_read && ptr_i);
   wire fin = !reset && owner != 0 && (!m_waitrequest || ab);
   wire [31:0] x_rd = ab ? 32'hDEADBEEF : m_readdata;
   always @(posedge clk) begin
      if (reset) begin
         owner <= 0; stalls <= 0; e_rd <= 0; e_wr <= 0; e_addr <= 0; e_wd <= 0; e_be <= 0;
         e_to <= 0; e_pr <= 0; ptr_i <= 0;
      end else if (owner == 0) begin
         if (take_d) begin
            owner <= 2; e_addr <= d_address; e_rd <= d_read && !d_write; e_wr <= d_write;
            e_be <= d_byteenable; e_wd <= d_writedata;
            if (d_read && d_write) e_pr <= 1;
         end else if (i_read) begin
            owner <= 1; e_addr <= i_address; e_rd <= 1; e_wr <= 0; e_be <= 4'hF; e_wd <= 0;
         end
      end else if (ab || !m_waitrequest) begin
         owner <= 0; stalls <= 0; e_rd <= 0; e_wr <= 0; ptr_i <= !ptr_i;
         if (ab) e_to <= 1;
      end else begin
         stalls <= stalls + 1;
      end
   end
   always @(negedge clk) begin
      chk("i_waitrequest", i_waitrequest, !(fin && owner == 1));
      chk("d_waitrequest", d_waitrequest, !(fin && owner == 2));
      chk("i_readdata", i_readdata, (fin && owner == 1) ? x_rd : 32'h0);
      chk("d_readdata", d_readdata, (fin && owner == 2) ? x_rd : 32'h0);
      chk("m_read", m_read, e_rd);
      chk("m_write", m_write, e_wr);
      chk("err_timeout", err_timeout, e_to);
      chk("err_protocol", err_protocol, e_pr);
      if (e_rd || e_wr) begin
         chk("m_address", m_address, e_addr);
         chk("m_byteenable", m_byteenable, e_be);
         chk("m_writedata", m_writedata, e_wd);
      end
   end
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   initial begin
      repeat (2) step;
      reset = 0;
      #1;
      chk("rst m_read", m_read, 0); chk("rst m_write", m_write, 0);
      chk("rst m_address", m_address, 0); chk("rst m_byteenable", m_byteenable, 0);
      chk("rst errors", {err_timeout, err_protocol}, 0); chk("rst i_wait", i_waitrequest, 1);
      // fetch, zero wait
      step; i_read = 1; i_address = 32'h100; m_readdata = 32'h2402000A; m_waitrequest = 0; #1;
      chk("t1 no strobe yet", m_read, 0);
      step; #1;
      chk("t1 m_read", m_read, 1); chk("t1 m_address", m_address, 32'h100);
      chk("t1 i_wait", i_waitrequest, 0); chk("t1 i_readdata", i_readdata, 32'h2402000A);
      step; i_read = 0; #1;
      chk("t1 m_read clear", m_read, 0); chk("t1 i_wait idle", i_waitrequest, 1);
      // simultaneous requests
      step; d_write = 1; d_address = 32'h200; d_writedata = 32'h12345678; d_byteenable = 4'b0011;
      i_read = 1; i_address = 32'h104; #1;
`ifndef MIPS_ARB_RR_EN
      step; #1;
      chk("t2 m_write", m_write, 1); chk("t2 m_address", m_address, 32'h200);
      chk("t2 be", m_byteenable, 4'b0011); chk("t2 wdata", m_writedata, 32'h12345678);
      chk("t2 i_wait during write", i_waitrequest, 1); chk("t2 d_wait", d_waitrequest, 0);
      step; d_write = 0; #1;
      chk("t2 gap m_read", m_read, 0); chk("t2 gap m_write", m_write, 0);
      chk("t2 gap i_wait", i_waitrequest, 1);
      step; #1;
      chk("t2 fetch m_read", m_read, 1); chk("t2 fetch addr", m_address, 32'h104);
      chk("t2 fetch be", m_byteenable, 4'hF); chk("t2 fetch i_wait", i_waitrequest, 0);
      step; i_read = 0; #1;
`else
      step; #1;
      chk("t2rr fetch first", m_read, 1); chk("t2rr fetch addr", m_address, 32'h104);
      chk("t2rr d_wait", d_waitrequest, 1);
      step; i_read = 0; #1;
      step; #1;
      chk("t2rr m_write", m_write, 1); chk("t2rr addr", m_address, 32'h200);
      step; d_write = 0; #1;
`endif
      // wait states, address held while requester address toggles
      step; d_read = 1; d_address = 32'h300; m_waitrequest = 1; m_readdata = 32'hCAFE0003; #1;
      for (int k = 0; k < 5; k++) begin
         step; d_address = d_address ^ 32'h10; #1;
         chk("t3 m_address held", m_address, 32'h300); chk("t3 d_wait", d_waitrequest, 1);
         chk("t3 d_readdata zero", d_readdata, 0);
      end
      step; m_waitrequest = 0; #1;
      chk("t3 d_wait done", d_waitrequest, 0); chk("t3 d_readdata", d_readdata, 32'hCAFE0003);
      step; d_read = 0; #1;
      chk("t3 d_readdata after", d_readdata, 0); chk("t3 d_wait after", d_waitrequest, 1);
      // watchdog abort
      step; i_read = 1; i_address = 32'h400; m_waitrequest = 1; #1;
      for (int k = 0; k < TO; k++) begin
         step; #1;
         chk("t4 stalled i_wait", i_waitrequest, 1);
      end
      step; #1;
      chk("t4 abort i_wait", i_waitrequest, 0); chk("t4 deadbeef", i_readdata, 32'hDEADBEEF);
      step; i_read = 0; #1;
      chk("t4 err_timeout", err_timeout, 1); chk("t4 m_read dropped", m_read, 0);
      step; i_read = 1; i_address = 32'h500; m_waitrequest = 0; m_readdata = 32'h11112222; #1;
      step; #1;
      chk("t4 next i_wait", i_waitrequest, 0); chk("t4 next data", i_readdata, 32'h11112222);
      step; i_read = 0; #1;
      // protocol error
      step; d_read = 1; d_write = 1; d_address = 32'h600; d_writedata = 32'hA5A5; d_byteenable = 4'hF; #1;
      chk("t5 err before accept", err_protocol, 0);
      step; #1;
      chk("t5 m_write", m_write, 1); chk("t5 m_read", m_read, 0); chk("t5 err_protocol", err_protocol, 1);
      step; d_read = 0; d_write = 0;
      repeat (2) step;
      #1;
      chk("t5 err sticky", err_protocol, 1);
      // reset during stalled grant
      step; i_read = 1; i_address = 32'h700; m_waitrequest = 1; #1;
      step; step; #1;
      chk("t6 stalled m_read", m_read, 1);
      reset = 1; #1;
      chk("t6 i_wait in reset", i_waitrequest, 1); chk("t6 d_wait in reset", d_waitrequest, 1);
      step; reset = 0; i_read = 0; #1;
      chk("t6 m_read", m_read, 0); chk("t6 m_write", m_write, 0);
      chk("t6 err_timeout", err_timeout, 0); chk("t6 err_protocol", err_protocol, 0);
      chk("t6 i_wait", i_waitrequest, 1);
      repeat (2) step;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
